// File: rtl/hilo_iter_div_pkg.sv
// Shared definitions for the HI/LO iterative divider (also used by the hazard unit).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hilo_iter_div_pkg;

  // Divider sequencer states; the hazard unit decodes the same encoding
  // to explain an MF stall.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } divState_t;

  // One restoring step per quotient bit.
  localparam int DIV_STEPS = 32;

  // Sign corrections applied to the unsigned results in FIX.
  typedef struct packed {
    logic quoNeg;
    logic remNeg;
  } signFix_t;

endpackage

// File: rtl/hilo_iter_div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial-subtract divisor.
// Latency: combinational, no registers.
// Backpressure: none; the caller decides when to register the outputs.
//
// Ports:
//   rem, quo  - current partial remainder / quotient-dividend shift register
//   divisor   - unsigned divisor magnitude
//   remNext, quoNext - values after this step
module hilo_iter_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext,
  output logic [WIDTH-1:0] quoNext
);

  logic [WIDTH:0] remShift;
  logic [WIDTH:0] trial;

  always_comb begin
    remShift = {rem, quo[WIDTH-1]};
    // rem < divisor on entry, so remShift < 2*divisor and the WIDTH+1-bit
    // difference never wraps: its top bit is exactly the borrow.
    trial    = remShift - {1'b0, divisor};
    if (trial[WIDTH]) begin
      remNext = remShift[WIDTH-1:0];
      quoNext = {quo[WIDTH-2:0], 1'b0};
    end else begin
      remNext = trial[WIDTH-1:0];
      quoNext = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/hilo_iter_div.sv
// Iterative DIV/DIVU unit owning the HI (remainder) and LO (quotient) registers.
// Latency: fixed 34 edges from the accepting start edge to valid hi/lo (done pulse).
// Backpressure: start is ignored while busy; stall_req holds MFHI/MFLO in decode.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   start, signed_op    - launch a division (sampled only when idle), 1 = signed DIV
//   dividend, divisor   - forwarded rs / rt operands, captured at start
//   mf_req              - an MFHI/MFLO is sitting in decode
//   hi, lo              - remainder / quotient architectural registers
//   busy, done          - division in flight / one-cycle result-written pulse
//   stall_req           - busy & mf_req, to the hazard unit
module hilo_iter_div
  import hilo_iter_div_pkg::*;
#(
  parameter int WIDTH = DIV_STEPS,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mf_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall_req
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  divState_t        state;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divReg;
  logic [CNT_W-1:0] count;
  signFix_t         fix;

  logic             dividendNeg;
  logic             divisorNeg;
  logic [WIDTH-1:0] dividendAbs;
  logic [WIDTH-1:0] divisorAbs;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;

  // Magnitudes are taken only for signed ops; 0x80000000 maps onto itself,
  // which is what gives the architected overflow result.
  assign dividendNeg = signed_op & dividend[WIDTH-1];
  assign divisorNeg  = signed_op & divisor[WIDTH-1];
  assign dividendAbs = dividendNeg ? -dividend : dividend;
  assign divisorAbs  = divisorNeg  ? -divisor  : divisor;

  hilo_iter_div_step #(.WIDTH(WIDTH)) uStep (
    .rem     (remReg),
    .quo     (quoReg),
    .divisor (divReg),
    .remNext (remNext),
    .quoNext (quoNext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      remReg <= '0;
      quoReg <= '0;
      divReg <= '0;
      count  <= '0;
      fix    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // quoReg starts as the dividend and fills with quotient bits
            // from the right as the dividend shifts out the top.
            remReg     <= '0;
            quoReg     <= dividendAbs;
            divReg     <= divisorAbs;
            fix.quoNeg <= dividendNeg ^ divisorNeg;
            fix.remNeg <= dividendNeg;
            count      <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          remReg <= remNext;
          quoReg <= quoNext;
          count  <= count + 1'b1;
          if (count == LAST_STEP) begin
            state <= FIX;
          end
        end
        FIX: begin
          lo    <= fix.quoNeg ? -quoReg : quoReg;
          hi    <= fix.remNeg ? -remReg : remReg;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign stall_req = busy & mf_req;

endmodule

// File: tb/tb_hilo_iter_div.sv
module tb_hilo_iter_div;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        mf_req = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall_req;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hilo_iter_div #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .mf_req    (mf_req),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .stall_req (stall_req)
  );

  // Reference: MIPS DIV/DIVU semantics from plain integer arithmetic.
  // Quotient truncates toward zero, remainder follows the dividend sign.
  // Divide by zero: magnitude quotient all ones, magnitude remainder |a|,
  // then the usual sign fixup.
  function automatic void refDiv(input bit s, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
    int     ia;
    int     ib;
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      ia = a;
      ib = b;
      sa = ia;
      sb = ib;
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  // Drives one start pulse, scrambles the operand inputs afterwards, and
  // waits (bounded) for done. Returns edges counted after the start edge.
  task automatic runOp(input bit s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] qOut, output logic [31:0] rOut,
                       output int edges, output bit busyOk, output bit stallOk);
    start     = 1'b1;
    signed_op = s;
    dividend  = a;
    divisor   = b;
    @(posedge clk); #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    signed_op = 1'($urandom_range(0, 1));
    busyOk    = (busy === 1'b1);
    stallOk   = (stall_req === mf_req);
    edges     = 0;
    while (edges <= 40) begin
      @(posedge clk); #1;
      edges++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busyOk = 1'b0;
      if (stall_req !== mf_req) stallOk = 1'b0;
    end
    qOut = lo;
    rOut = hi;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hi !== 32'd0)       begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0)       begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [31:0] vA [5];
    logic [31:0] vB [5];
    bit          vS [5];
    logic [31:0] vQ [5];
    logic [31:0] vR [5];
    logic [31:0] q, r;
    int          edges;
    bit          busyOk, stallOk;
    vS[0] = 0; vA[0] = 32'd100;        vB[0] = 32'd7;          vQ[0] = 32'd14;         vR[0] = 32'd2;
    vS[1] = 1; vA[1] = 32'hFFFF_FFF9;  vB[1] = 32'd2;          vQ[1] = 32'hFFFF_FFFD;  vR[1] = 32'hFFFF_FFFF;
    vS[2] = 1; vA[2] = 32'd7;          vB[2] = 32'hFFFF_FFFE;  vQ[2] = 32'hFFFF_FFFD;  vR[2] = 32'd1;
    vS[3] = 1; vA[3] = 32'h8000_0000;  vB[3] = 32'hFFFF_FFFF;  vQ[3] = 32'h8000_0000;  vR[3] = 32'd0;
    vS[4] = 0; vA[4] = 32'd7;          vB[4] = 32'd0;          vQ[4] = 32'hFFFF_FFFF;  vR[4] = 32'd7;
    for (int i = 0; i < 5; i++) begin
      runOp(vS[i], vA[i], vB[i], q, r, edges, busyOk, stallOk);
      checks++; if (q !== vQ[i]) begin errors++; $display("FAIL dir%0d_lo got=%h exp=%h", i, q, vQ[i]); end
      checks++; if (r !== vR[i]) begin errors++; $display("FAIL dir%0d_hi got=%h exp=%h", i, r, vR[i]); end
      checks++; if (edges != 33) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=33", i, edges); end
      checks++; if (!busyOk)     begin errors++; $display("FAIL dir%0d_busy got=dropped exp=held", i); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_done got=%b exp=0", i, busy); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done); end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, q, r, eq, er;
    bit          s;
    int          edges;
    bit          busyOk, stallOk;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      refDiv(s, a, b, eq, er);
      runOp(s, a, b, q, r, edges, busyOk, stallOk);
      checks++; if (q !== eq) begin errors++; $display("FAIL rnd%0d_lo s=%0d a=%h b=%h got=%h exp=%h", i, s, a, b, q, eq); end
      checks++; if (r !== er) begin errors++; $display("FAIL rnd%0d_hi s=%0d a=%h b=%h got=%h exp=%h", i, s, a, b, r, er); end
      checks++; if (edges != 33) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=33", i, edges); end
    end
  endtask

  task automatic test_stall_ignore;
    int  n;
    bit  stallOk;
    mf_req    = 1'b1;
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd9;
    @(posedge clk); #1;
    start   = 1'b0;
    stallOk = (stall_req === 1'b1);
    n       = 0;
    while (n <= 40) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) break;
      if (stall_req !== 1'b1) stallOk = 1'b0;
      // A second DIV arriving mid-run must be dropped.
      if (n == 5) begin
        start = 1'b1; signed_op = 1'b1; dividend = 32'd50; divisor = 32'd5;
      end else begin
        start = 1'b0;
      end
    end
    checks++; if (!stallOk)  begin errors++; $display("FAIL stall_busy got=dropped exp=held"); end
    checks++; if (n != 33)   begin errors++; $display("FAIL stall_latency got=%0d exp=33", n); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL stall_done_cycle got=%b exp=0", stall_req); end
    checks++; if (lo !== 32'd111) begin errors++; $display("FAIL ignore_lo got=%h exp=%h", lo, 32'd111); end
    checks++; if (hi !== 32'd1)   begin errors++; $display("FAIL ignore_hi got=%h exp=%h", hi, 32'd1); end
    @(posedge clk); #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL stall_after got=%b exp=0", stall_req); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL ignore_no_queue got busy=%b exp=0", busy); end
    mf_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] q, r;
    int          edges;
    bit          busyOk, stallOk;
    runOp(1'b0, 32'd68, 32'd7, q, r, edges, busyOk, stallOk);
    checks++; if (q !== 32'd9) begin errors++; $display("FAIL pre_reset_lo got=%h exp=9", q); end
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL pre_reset_hi got=%h exp=5", r); end
    start = 1'b1; signed_op = 1'b0; dividend = 32'd1234; divisor = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL midreset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0)  begin errors++; $display("FAIL midreset_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got=%b exp=0", done); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    runOp(1'b0, 32'd9, 32'd3, q, r, edges, busyOk, stallOk);
    checks++; if (q !== 32'd3) begin errors++; $display("FAIL post_reset_lo got=%h exp=3", q); end
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL post_reset_hi got=%h exp=0", r); end
    checks++; if (edges != 33) begin errors++; $display("FAIL post_reset_latency got=%0d exp=33", edges); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] qA, rA, eqA, erA, eqB, erB, aB, bB;
    int          edges, n;
    bit          busyOk, stallOk, holdOk;
    refDiv(1'b1, 32'hFFFF_F000, 32'd37, eqA, erA);
    aB = $urandom;
    bB = 32'($urandom_range(1, 1000));
    refDiv(1'b0, aB, bB, eqB, erB);
    runOp(1'b1, 32'hFFFF_F000, 32'd37, qA, rA, edges, busyOk, stallOk);
    checks++; if (qA !== eqA || rA !== erA) begin errors++; $display("FAIL b2b_first got=%h/%h exp=%h/%h", qA, rA, eqA, erA); end
    // Start held high through the done cycle.
    start = 1'b1; signed_op = 1'b0; dividend = aB; divisor = bB;
    @(posedge clk); #1;
    start  = 1'b0;
    n      = 1;
    holdOk = (lo === eqA) && (hi === erA);
    while (n <= 40 && done !== 1'b1) begin
      @(posedge clk); #1;
      n++;
      if (done !== 1'b1 && (lo !== eqA || hi !== erA)) holdOk = 1'b0;
    end
    checks++; if (!holdOk) begin errors++; $display("FAIL b2b_hold got=changed exp=first result held"); end
    checks++; if (n != 34) begin errors++; $display("FAIL b2b_latency got=%0d exp=34", n); end
    checks++; if (lo !== eqB) begin errors++; $display("FAIL b2b_lo got=%h exp=%h", lo, eqB); end
    checks++; if (hi !== erB) begin errors++; $display("FAIL b2b_hi got=%h exp=%h", hi, erB); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
